conv_layer_sequencer: RTL and testbench
=======================================

# conv_layer_sequencer

Control block that runs one MAC dot-product engine over a full convolution layer: every output position of every filter in a filter bank. It generates image/filter memory read addresses, the MAC enable/clear/last strobes and the output-memory write strobe and address. It sits between the layer-level start/done handshake and the image RAM, filter RAM, dot-product unit and output RAM. It replaces the per-convolution combinational next-state counting with registered nested counters.

## Interface
- IMG_ROWS, 15, image height
- IMG_COLS, 14, image width
- FLT_ROWS, 3, kernel height (1..IMG_ROWS)
- FLT_COLS, 3, kernel width (1..IMG_COLS)
- NUM_FILTERS, 4, filters in bank, stored back-to-back in filter RAM
- IMG_AW, 16, image RAM address width
- FLT_AW, 8, filter RAM address width
- OUT_AW, 16, output RAM address width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  single-cycle pulse after the final output write
- img_rd_en  out  1  image RAM read enable (issue stage)
- img_addr  out  IMG_AW  image read address
- flt_rd_en  out  1  filter RAM read enable (issue stage)
- flt_addr  out  FLT_AW  filter read address
- mac_en  out  1  accumulate current RAM data (issue delayed 1 cycle)
- mac_clear  out  1  with mac_en: first tap of a window; accumulator loads the product instead of adding it
- mac_last  out  1  with mac_en: last tap of a window
- out_we  out  1  output RAM write strobe, 1 cycle
- out_addr  out  OUT_AW  output write address

## Operation
- Derived values: OH=IMG_ROWS-FLT_ROWS+1, OW=IMG_COLS-FLT_COLS+1, TAPS=FLT_ROWS*FLT_COLS, N=NUM_FILTERS*OH*OW*TAPS.
- States: IDLE -> RUN on start. RUN -> DRAIN after the last tap is issued. DRAIN -> DONE once the pipeline is empty, after the final out_we. DONE -> IDLE unconditionally.
- Loop order, outermost first: filter f, output row r, output col c, kernel row kr, kernel col kc.
- One tap is issued per RUN cycle. There are no bubbles between windows, rows or filters.
- img_addr=(r+kr)*IMG_COLS+c+kc.
- flt_addr=f*TAPS+kr*FLT_COLS+kc.
- out_addr=f*OH*OW+r*OW+c.
- Address arithmetic uses internal widths sufficient for the full range, then truncates to the port width. Parameter legality requires IMG_ROWS*IMG_COLS<=2^IMG_AW, NUM_FILTERS*TAPS<=2^FLT_AW and NUM_FILTERS*OH*OW<=2^OUT_AW.
- img_rd_en and flt_rd_en are high exactly in RUN issue cycles. Addresses hold their last value otherwise.
- mac_en, mac_clear and mac_last are the issue-stage valid and the first/last-tap flags, registered once (RAMs have 1-cycle read latency).
- out_we and out_addr are mac_last and the window index, registered once more (accumulator result is registered).
- start in RUN, DRAIN or DONE is ignored, not queued. If start is held continuously, the next run is accepted in the IDLE cycle following DONE.
- For a 1x1 kernel, mac_clear and mac_last assert together on every mac_en.
- reset at any time forces state IDLE, clears all counters and pipeline valids, and drives all outputs to 0. No out_we or done may appear after reset until a new start.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE.
- Issue cycles are 1..N. mac_en is high in cycles 2..N+1.
- The final out_we is in cycle N+2. done and the last busy cycle are in cycle N+3. IDLE resumes at cycle N+4.
- Per window: mac_clear appears 1 cycle after the window's first issue. out_we appears 1 cycle after that window's mac_last.
- mac_last of window k and mac_clear of window k+1 fall in adjacent cycles.
- Reset values: busy, done, img_rd_en, flt_rd_en, mac_en, mac_clear, mac_last and out_we are 0. img_addr, flt_addr and out_addr are 0.

## Structure
- Shared package conv_pkg holds:
  - derived localparams OH, OW, TAPS;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the address-width check constants.
- Sub-module conv_addr_gen holds the five nested counters (with wrap/carry chain) and the address arithmetic. It outputs addresses, first/last-tap flags, window index and a final-tap flag.
- The top level holds the FSM, the 2-stage valid/flag pipeline and the busy/done logic.

## Test plan
- Default params, start pulse: first 9 img_addr 0,1,2,14,15,16,28,29,30. flt_addr 0..8. mac_clear in cycle 2, mac_last in cycle 10, out_we with out_addr 0 in cycle 11.
- Window stepping: second window img_addr 1,2,3,15,16,17,29,30,31. Window 12 (r=1, c=0) starts at img_addr 14. mac_last (cycle 10) and mac_clear (cycle 11) adjacent.
- Full run: exactly 624 out_we with out_addr 0..623 in order. Filter 1 taps use flt_addr 9..17. done in cycle 5619 only. busy high in cycles 1..5619.
- reset asserted in cycle 100: all outputs 0 from cycle 101, no further out_we or done. New start restarts at img_addr 0, out_addr 0.
- start pulsed in cycle 50 and held through DONE: first run is unaffected. Second run's first issue is in the cycle after returning to IDLE plus 1.
- FLT_ROWS=FLT_COLS=1, NUM_FILTERS=1: 210 out_we. mac_clear and mac_last coincide on every mac_en. done in cycle 213.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, default geometry and address-width helpers for the convolution layer sequencer.
package conv_pkg;

    localparam int IMG_ROWS_DEF    = 15;
    localparam int IMG_COLS_DEF    = 14;
    localparam int FLT_ROWS_DEF    = 3;
    localparam int FLT_COLS_DEF    = 3;
    localparam int NUM_FILTERS_DEF = 4;
    localparam int IMG_AW_DEF      = 16;
    localparam int FLT_AW_DEF      = 8;
    localparam int OUT_AW_DEF      = 16;

    function automatic int out_dim(input int img, input int flt);
        return img - flt + 1;
    endfunction

    function automatic bit span_fits(input longint span, input int aw);
        return span <= (longint'(1) << aw);
    endfunction

    localparam int OH   = out_dim(IMG_ROWS_DEF, FLT_ROWS_DEF);
    localparam int OW   = out_dim(IMG_COLS_DEF, FLT_COLS_DEF);
    localparam int TAPS = FLT_ROWS_DEF * FLT_COLS_DEF;

    localparam longint IMG_SPAN = longint'(IMG_ROWS_DEF) * IMG_COLS_DEF;
    localparam longint FLT_SPAN = longint'(NUM_FILTERS_DEF) * TAPS;
    localparam longint OUT_SPAN = longint'(NUM_FILTERS_DEF) * OH * OW;
    localparam bit     DEF_WIDTHS_OK = span_fits(IMG_SPAN, IMG_AW_DEF) &&
                                       span_fits(FLT_SPAN, FLT_AW_DEF) &&
                                       span_fits(OUT_SPAN, OUT_AW_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Layer handshake plus RAM / MAC / output strobes between the sequencer (master) and its datapath (slave).
interface conv_layer_sequencer_if
    import conv_pkg::*;
#(
    parameter int IMG_AW = IMG_AW_DEF,
    parameter int FLT_AW = FLT_AW_DEF,
    parameter int OUT_AW = OUT_AW_DEF
);
    logic              start;
    logic              busy;
    logic              done;
    logic              img_rd_en;
    logic [IMG_AW-1:0] img_addr;
    logic              flt_rd_en;
    logic [FLT_AW-1:0] flt_addr;
    logic              mac_en;
    logic              mac_clear;
    logic              mac_last;
    logic              out_we;
    logic [OUT_AW-1:0] out_addr;

    modport master (
        input  start,
        output busy, done, img_rd_en, img_addr, flt_rd_en, flt_addr,
               mac_en, mac_clear, mac_last, out_we, out_addr
    );

    modport slave (
        output start,
        input  busy, done, img_rd_en, img_addr, flt_rd_en, flt_addr,
               mac_en, mac_clear, mac_last, out_we, out_addr
    );
endinterface

// File: rtl/conv_addr_gen.sv
// Nested filter/row/col/kernel-row/kernel-col counters and the RAM / window address arithmetic.
// Addresses are combinational from the counters; counters freeze on the final tap until the next clear.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_ROWS    = IMG_ROWS_DEF,
    parameter int IMG_COLS    = IMG_COLS_DEF,
    parameter int FLT_ROWS    = FLT_ROWS_DEF,
    parameter int FLT_COLS    = FLT_COLS_DEF,
    parameter int NUM_FILTERS = NUM_FILTERS_DEF,
    parameter int IMG_AW      = IMG_AW_DEF,
    parameter int FLT_AW      = FLT_AW_DEF,
    parameter int OUT_AW      = OUT_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [IMG_AW-1:0] img_addr_o,
    output logic [FLT_AW-1:0] flt_addr_o,
    output logic [OUT_AW-1:0] win_o,
    output logic              first_o,
    output logic              last_o,
    output logic              final_o
);
    localparam int OH_L   = out_dim(IMG_ROWS, FLT_ROWS);
    localparam int OW_L   = out_dim(IMG_COLS, FLT_COLS);
    localparam int TAPS_L = FLT_ROWS * FLT_COLS;
    localparam int CW     = 16;

    logic [CW-1:0] f_q, f_d, r_q, r_d, c_q, c_d, kr_q, kr_d, kc_q, kc_d;
    logic          kc_wrap, kr_wrap, c_wrap, r_wrap, f_wrap;

    assign kc_wrap = (kc_q == CW'(FLT_COLS - 1));
    assign kr_wrap = (kr_q == CW'(FLT_ROWS - 1));
    assign c_wrap  = (c_q  == CW'(OW_L - 1));
    assign r_wrap  = (r_q  == CW'(OH_L - 1));
    assign f_wrap  = (f_q  == CW'(NUM_FILTERS - 1));

    assign first_o = (kc_q == '0) && (kr_q == '0);
    assign last_o  = kc_wrap && kr_wrap;
    assign final_o = last_o && c_wrap && r_wrap && f_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q  <= '0;
            r_q  <= '0;
            c_q  <= '0;
            kr_q <= '0;
            kc_q <= '0;
        end else begin
            f_q  <= f_d;
            r_q  <= r_d;
            c_q  <= c_d;
            kr_q <= kr_d;
            kc_q <= kc_d;
        end
    end

    // Carry ripples kc -> kr -> c -> r -> f; holding on the final tap keeps the last addresses visible.
    always_comb begin
        f_d  = f_q;
        r_d  = r_q;
        c_d  = c_q;
        kr_d = kr_q;
        kc_d = kc_q;
        if (clear_i) begin
            f_d  = '0;
            r_d  = '0;
            c_d  = '0;
            kr_d = '0;
            kc_d = '0;
        end else if (adv_i && !final_o) begin
            kc_d = kc_wrap ? '0 : kc_q + 1'b1;
            if (kc_wrap) begin
                kr_d = kr_wrap ? '0 : kr_q + 1'b1;
                if (kr_wrap) begin
                    c_d = c_wrap ? '0 : c_q + 1'b1;
                    if (c_wrap) begin
                        r_d = r_wrap ? '0 : r_q + 1'b1;
                        if (r_wrap) begin
                            f_d = f_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign img_addr_o = IMG_AW'((32'(r_q) + 32'(kr_q)) * 32'(IMG_COLS) + 32'(c_q) + 32'(kc_q));
    assign flt_addr_o = FLT_AW'(32'(f_q) * 32'(TAPS_L) + 32'(kr_q) * 32'(FLT_COLS) + 32'(kc_q));
    assign win_o      = OUT_AW'(32'(f_q) * 32'(OH_L * OW_L) + 32'(r_q) * 32'(OW_L) + 32'(c_q));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs one MAC engine over a whole conv layer: one tap per RUN cycle, mac_* one cycle after issue,
// out_we one cycle after mac_last; no backpressure, start is ignored unless IDLE.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_ROWS    = IMG_ROWS_DEF,
    parameter int IMG_COLS    = IMG_COLS_DEF,
    parameter int FLT_ROWS    = FLT_ROWS_DEF,
    parameter int FLT_COLS    = FLT_COLS_DEF,
    parameter int NUM_FILTERS = NUM_FILTERS_DEF,
    parameter int IMG_AW      = IMG_AW_DEF,
    parameter int FLT_AW      = FLT_AW_DEF,
    parameter int OUT_AW      = OUT_AW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_layer_sequencer_if.master bus
);
    localparam int OH_L = out_dim(IMG_ROWS, FLT_ROWS);
    localparam int OW_L = out_dim(IMG_COLS, FLT_COLS);

    if (!span_fits(longint'(IMG_ROWS) * IMG_COLS, IMG_AW)) begin : g_img_aw_chk
        $error("IMG_AW too narrow for IMG_ROWS*IMG_COLS");
    end
    if (!span_fits(longint'(NUM_FILTERS) * FLT_ROWS * FLT_COLS, FLT_AW)) begin : g_flt_aw_chk
        $error("FLT_AW too narrow for the filter bank");
    end
    if (!span_fits(longint'(NUM_FILTERS) * OH_L * OW_L, OUT_AW)) begin : g_out_aw_chk
        $error("OUT_AW too narrow for the output map");
    end

    state_e            state_q, state_d;
    logic              issue, busy, done, start_acc;
    logic              first_tap, last_tap, final_tap;
    logic [IMG_AW-1:0] img_addr;
    logic [FLT_AW-1:0] flt_addr;
    logic [OUT_AW-1:0] win;
    logic              mac_en_q, mac_clear_q, mac_last_q, out_we_q;
    logic [OUT_AW-1:0] win_q, out_addr_q;

    assign start_acc = (state_q == IDLE) && bus.start;

    conv_addr_gen #(
        .IMG_ROWS    (IMG_ROWS),
        .IMG_COLS    (IMG_COLS),
        .FLT_ROWS    (FLT_ROWS),
        .FLT_COLS    (FLT_COLS),
        .NUM_FILTERS (NUM_FILTERS),
        .IMG_AW      (IMG_AW),
        .FLT_AW      (FLT_AW),
        .OUT_AW      (OUT_AW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (start_acc),
        .adv_i      (issue),
        .img_addr_o (img_addr),
        .flt_addr_o (flt_addr),
        .win_o      (win),
        .first_o    (first_tap),
        .last_o     (last_tap),
        .final_o    (final_tap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN ends once stage 1 is empty: the cycle the final out_we is on the port.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (final_tap) state_d = DRAIN;
            DRAIN:   if (!mac_en_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue = (state_q == RUN);
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mac_en_q    <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_last_q  <= 1'b0;
            out_we_q    <= 1'b0;
            win_q       <= '0;
            out_addr_q  <= '0;
        end else begin
            mac_en_q    <= issue;
            mac_clear_q <= issue && first_tap;
            mac_last_q  <= issue && last_tap;
            out_we_q    <= mac_last_q;
            if (issue) begin
                win_q <= win;
            end
            if (mac_last_q) begin
                out_addr_q <= win_q;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.img_rd_en = issue;
    assign bus.flt_rd_en = issue;
    assign bus.img_addr  = img_addr;
    assign bus.flt_addr  = flt_addr;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clear = mac_clear_q;
    assign bus.mac_last  = mac_last_q;
    assign bus.out_we    = out_we_q;
    assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench: default 3x3x4 sequencer and a 1x1x1 sequencer checked cycle by cycle against a loop-index model.
module tb_conv_layer_sequencer;

    localparam int N0 = 4 * 13 * 12 * 9;
    localparam int N1 = 15 * 14;
    localparam int F1_LO = 13 * 12 * 9;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        img_rd_en;
        logic [15:0] img_addr;
        logic        flt_rd_en;
        logic [7:0]  flt_addr;
        logic        mac_en;
        logic        mac_clear;
        logic        mac_last;
        logic        out_we;
        logic [15:0] out_addr;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    obs_t prev0 = '0;
    obs_t prev1 = '0;

    always #5 clk = ~clk;

    conv_layer_sequencer_if bus0 ();
    conv_layer_sequencer_if bus1 ();

    conv_layer_sequencer dut0 (.clk(clk), .reset(reset), .bus(bus0));
    conv_layer_sequencer #(.FLT_ROWS(1), .FLT_COLS(1), .NUM_FILTERS(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    function automatic obs_t sample(input bit which);
        obs_t o;
        if (!which) begin
            o = {bus0.busy, bus0.done, bus0.img_rd_en, bus0.img_addr, bus0.flt_rd_en, bus0.flt_addr,
                 bus0.mac_en, bus0.mac_clear, bus0.mac_last, bus0.out_we, bus0.out_addr};
        end else begin
            o = {bus1.busy, bus1.done, bus1.img_rd_en, bus1.img_addr, bus1.flt_rd_en, bus1.flt_addr,
                 bus1.mac_en, bus1.mac_clear, bus1.mac_last, bus1.out_we, bus1.out_addr};
        end
        return o;
    endfunction

    // Expected outputs in cycle t of a run whose start was sampled at edge 0.
    // Tap i = t-1 is split into (f, r, c, kr, kc) by plain division in loop order.
    function automatic obs_t model(input int t, input int ir, input int ic, input int fr,
                                   input int fc, input int nf, input obs_t prev);
        obs_t o;
        int oh, ow, taps, n, i, w, f, r, c, kr, kc;
        oh = ir - fr + 1;
        ow = ic - fc + 1;
        taps = fr * fc;
        n = nf * oh * ow * taps;
        o = prev;
        o.busy = (t >= 1) && (t <= n + 3);
        o.done = (t == n + 3);
        o.img_rd_en = (t >= 1) && (t <= n);
        o.flt_rd_en = o.img_rd_en;
        if (o.img_rd_en) begin
            i = t - 1;
            kc = i % fc;
            kr = (i / fc) % fr;
            w = i / taps;
            c = w % ow;
            r = (w / ow) % oh;
            f = w / (oh * ow);
            o.img_addr = 16'((r + kr) * ic + c + kc);
            o.flt_addr = 8'(f * taps + kr * fc + kc);
        end
        i = t - 2;
        o.mac_en = (i >= 0) && (i < n);
        o.mac_clear = o.mac_en && (i % taps == 0);
        o.mac_last = o.mac_en && (i % taps == taps - 1);
        i = t - 3;
        o.out_we = (i >= 0) && (i < n) && (i % taps == taps - 1);
        if (o.out_we) begin
            w = i / taps;
            c = w % ow;
            r = (w / ow) % oh;
            f = w / (oh * ow);
            o.out_addr = 16'(f * oh * ow + r * ow + c);
        end
        return o;
    endfunction

    task automatic test_reset();
        obs_t a0, a1;
        reset = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            a0 = sample(1'b0);
            a1 = sample(1'b1);
            compared += 2;
            if (a0 !== '0) begin
                mismatched++;
                $display("FAIL reset_dut0 t=%0d actual=%h required=0", t, a0);
            end
            if (a1 !== '0) begin
                mismatched++;
                $display("FAIL reset_dut1 t=%0d actual=%h required=0", t, a1);
            end
            if (t == 2) reset = 1'b0;
        end
        prev0 = '0;
        prev1 = '0;
    endtask

    task automatic test_full_run();
        int img0[9] = '{0, 1, 2, 14, 15, 16, 28, 29, 30};
        int img1[9] = '{1, 2, 3, 15, 16, 17, 29, 30, 31};
        obs_t a, e, am, em;
        int nwe = 0;
        int ndone = 0;
        int done_at = -1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus0.start = 1'b1;
        for (int t = 1; t <= N0 + 8; t++) begin
            @(negedge clk);
            a = sample(1'b0);
            e = model(t, 15, 14, 3, 3, 4, prev0);
            prev0 = e;
            am = a;
            em = e;
            if (!e.out_we) begin
                am.out_addr = '0;
                em.out_addr = '0;
            end
            compared++;
            if (am !== em) begin
                mismatched++;
                $display("FAIL full_run t=%0d actual=%h required=%h", t, am, em);
            end
            if (t <= 9) begin
                compared++;
                if (a.img_addr !== 16'(img0[t-1]) || a.flt_addr !== 8'(t - 1)) begin
                    mismatched++;
                    $display("FAIL first_window t=%0d img/flt=%0d/%0d required %0d/%0d",
                             t, a.img_addr, a.flt_addr, img0[t-1], t - 1);
                end
            end else if (t <= 18) begin
                compared++;
                if (a.img_addr !== 16'(img1[t-10])) begin
                    mismatched++;
                    $display("FAIL second_window t=%0d img_addr=%0d required %0d", t, a.img_addr, img1[t-10]);
                end
            end
            if (t == 10) begin
                compared++;
                if (a.mac_last !== 1'b1 || a.mac_clear !== 1'b0) begin
                    mismatched++;
                    $display("FAIL last_w0 clear/last=%b%b required 01", a.mac_clear, a.mac_last);
                end
            end
            if (t == 11) begin
                compared++;
                if (a.mac_clear !== 1'b1 || a.out_we !== 1'b1 || a.out_addr !== 16'd0) begin
                    mismatched++;
                    $display("FAIL clear_w1_we_w0 clear=%b we=%b out_addr=%0d required 1 1 0",
                             a.mac_clear, a.out_we, a.out_addr);
                end
            end
            if (t == 109) begin
                compared++;
                if (a.img_addr !== 16'd14) begin
                    mismatched++;
                    $display("FAIL window12_start img_addr=%0d required 14", a.img_addr);
                end
            end
            if (t - 1 >= F1_LO && t - 1 < 2 * F1_LO) begin
                compared++;
                if (a.flt_addr < 8'd9 || a.flt_addr > 8'd17) begin
                    mismatched++;
                    $display("FAIL flt1_range t=%0d flt_addr=%0d required 9..17", t, a.flt_addr);
                end
            end
            if (a.out_we === 1'b1) begin
                compared++;
                if (a.out_addr !== 16'(nwe)) begin
                    mismatched++;
                    $display("FAIL out_order t=%0d out_addr=%0d required %0d", t, a.out_addr, nwe);
                end
                nwe++;
            end
            if (a.done === 1'b1) begin
                ndone++;
                done_at = t;
            end
            bus0.start = (t <= N0 + 3) && ($urandom_range(0, 96) == 0);
        end
        compared++;
        if (nwe != 624) begin
            mismatched++;
            $display("FAIL out_we_count actual=%0d required=624", nwe);
        end
        compared++;
        if (ndone != 1 || done_at != N0 + 3) begin
            mismatched++;
            $display("FAIL done_cycle count=%0d at=%0d required 1 at %0d", ndone, done_at, N0 + 3);
        end
    endtask

    task automatic test_back_to_back();
        obs_t a, e, am, em;
        int s, tm, ndone;
        ndone = 0;
        s = 50 + int'($urandom_range(0, 50));
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus0.start = 1'b1;
        for (int t = 1; t <= 2 * (N0 + 4) + 4; t++) begin
            @(negedge clk);
            tm = (t <= N0 + 4) ? t : t - (N0 + 4);
            a = sample(1'b0);
            e = model(tm, 15, 14, 3, 3, 4, prev0);
            prev0 = e;
            am = a;
            em = e;
            if (!e.out_we) begin
                am.out_addr = '0;
                em.out_addr = '0;
            end
            compared++;
            if (am !== em) begin
                mismatched++;
                $display("FAIL back_to_back t=%0d actual=%h required=%h", t, am, em);
            end
            if (t == N0 + 5) begin
                compared++;
                if (a.img_rd_en !== 1'b1 || a.img_addr !== 16'd0 || a.flt_addr !== 8'd0) begin
                    mismatched++;
                    $display("FAIL second_first_issue rd_en=%b img=%0d flt=%0d required 1 0 0",
                             a.img_rd_en, a.img_addr, a.flt_addr);
                end
            end
            if (a.done === 1'b1) ndone++;
            if (t == 1) bus0.start = 1'b0;
            if (t == s) bus0.start = 1'b1;
            if (t == N0 + 5) bus0.start = 1'b0;
        end
        compared++;
        if (ndone != 2) begin
            mismatched++;
            $display("FAIL back_to_back_done_count actual=%0d required=2", ndone);
        end
    endtask

    task automatic test_reset_midrun();
        obs_t a, e, am, em;
        int rc;
        rc = int'($urandom_range(60, 400));
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus0.start = 1'b1;
        for (int t = 1; t <= rc; t++) begin
            @(negedge clk);
            a = sample(1'b0);
            e = model(t, 15, 14, 3, 3, 4, prev0);
            prev0 = e;
            am = a;
            em = e;
            if (!e.out_we) begin
                am.out_addr = '0;
                em.out_addr = '0;
            end
            compared++;
            if (am !== em) begin
                mismatched++;
                $display("FAIL pre_reset t=%0d actual=%h required=%h", t, am, em);
            end
            if (t == 1) bus0.start = 1'b0;
            if (t == rc) reset = 1'b1;
        end
        for (int t = rc + 1; t <= rc + 60; t++) begin
            @(negedge clk);
            a = sample(1'b0);
            compared++;
            if (a !== '0) begin
                mismatched++;
                $display("FAIL reset_quiet t=%0d actual=%h required=0", t, a);
            end
            if (t == rc + 3) reset = 1'b0;
        end
        prev0 = '0;
        bus0.start = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            a = sample(1'b0);
            e = model(t, 15, 14, 3, 3, 4, prev0);
            prev0 = e;
            am = a;
            em = e;
            if (!e.out_we) begin
                am.out_addr = '0;
                em.out_addr = '0;
            end
            compared++;
            if (am !== em) begin
                mismatched++;
                $display("FAIL restart t=%0d actual=%h required=%h", t, am, em);
            end
            if (t == 1) begin
                bus0.start = 1'b0;
                compared++;
                if (a.img_addr !== 16'd0 || a.img_rd_en !== 1'b1) begin
                    mismatched++;
                    $display("FAIL restart_addr img_addr=%0d rd_en=%b required 0 1", a.img_addr, a.img_rd_en);
                end
            end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev0 = '0;
        prev1 = '0;
    endtask

    task automatic test_1x1_kernel();
        obs_t a, e, am, em;
        int nwe = 0;
        int ndone = 0;
        int done_at = -1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus1.start = 1'b1;
        for (int t = 1; t <= N1 + 6; t++) begin
            @(negedge clk);
            a = sample(1'b1);
            e = model(t, 15, 14, 1, 1, 1, prev1);
            prev1 = e;
            am = a;
            em = e;
            if (!e.out_we) begin
                am.out_addr = '0;
                em.out_addr = '0;
            end
            compared++;
            if (am !== em) begin
                mismatched++;
                $display("FAIL kernel1x1 t=%0d actual=%h required=%h", t, am, em);
            end
            if (a.mac_en === 1'b1) begin
                compared++;
                if (a.mac_clear !== 1'b1 || a.mac_last !== 1'b1) begin
                    mismatched++;
                    $display("FAIL clear_last_1x1 t=%0d clear/last=%b%b required 11", t, a.mac_clear, a.mac_last);
                end
            end
            if (a.out_we === 1'b1) nwe++;
            if (a.done === 1'b1) begin
                ndone++;
                done_at = t;
            end
            if (t == 1) bus1.start = 1'b0;
        end
        compared++;
        if (nwe != N1) begin
            mismatched++;
            $display("FAIL out_we_count_1x1 actual=%0d required=%0d", nwe, N1);
        end
        compared++;
        if (ndone != 1 || done_at != 213) begin
            mismatched++;
            $display("FAIL done_cycle_1x1 count=%0d at=%0d required 1 at 213", ndone, done_at);
        end
    endtask

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        test_reset();
        test_full_run();
        test_back_to_back();
        test_reset_midrun();
        test_1x1_kernel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached, compared=%0d", compared);
        $fatal(1, "time limit");
    end

endmodule
